apb_bridge_ahbl: RTL and testbench

APB_BRIDGE_AHBL -- requirements
Module: apb_bridge_ahbl

---
 rtl/apb_bridge_ahbl.sv | 202 ++++++++++++++++++++
 tb/tb_apb_bridge_ahbl.sv | 568 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_bridge_ahbl.sv
// AHB-Lite slave to APB master bridge with a 16 KB window split into
// four 4 KB APB slots, decode-error checks and an APB access timeout.
//
// Ports
//   pll_core_cpuclk  : clock, rising edge
//   pad_cpu_rst_b    : asynchronous active-low reset
//   bridge_hsel      : AHB-Lite slave select
//   biu_pad_haddr    : AHB address (window [31:14], slot [13:12], offset [11:0])
//   biu_pad_htrans   : AHB transfer type, NONSEQ/SEQ start a transfer
//   biu_pad_hwrite   : 1 = write
//   biu_pad_hsize    : 0 = byte, 1 = half, 2 = word
//   biu_pad_hwdata   : write data, valid in the data phase
//   pad_biu_hrdata   : read data, held until the next completed read
//   pad_biu_hready   : transfer done / slave ready
//   pad_biu_hresp    : 2'b00 = OKAY, 2'b01 = ERROR
//   apb_psel         : one-hot APB slave select
//   apb_penable      : APB access phase
//   apb_paddr        : offset within the slot
//   apb_pwrite       : APB direction
//   apb_pwdata       : APB write data
//   apb_pstrb        : APB byte strobes (zero on reads)
//   apb_prdata       : read data from the selected slave
//   apb_pready       : slave ready
//   apb_pslverr      : slave error

module apb_bridge_ahbl #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter logic [7:0]  TIMEOUT   = 8'd255
) (
    input  logic        pll_core_cpuclk,
    input  logic        pad_cpu_rst_b,
    input  logic        bridge_hsel,
    input  logic [31:0] biu_pad_haddr,
    input  logic [1:0]  biu_pad_htrans,
    input  logic        biu_pad_hwrite,
    input  logic [2:0]  biu_pad_hsize,
    input  logic [31:0] biu_pad_hwdata,
    output logic [31:0] pad_biu_hrdata,
    output logic        pad_biu_hready,
    output logic [1:0]  pad_biu_hresp,
    output logic [3:0]  apb_psel,
    output logic        apb_penable,
    output logic [11:0] apb_paddr,
    output logic        apb_pwrite,
    output logic [31:0] apb_pwdata,
    output logic [3:0]  apb_pstrb,
    input  logic [31:0] apb_prdata,
    input  logic        apb_pready,
    input  logic        apb_pslverr
);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SETUP,
        ACCESS,
        RESP,
        ERR1,
        ERR2
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic        phase_req;
    logic        hready_int;
    logic        accept;
    logic        win_err;
    logic        size_err;
    logic        align_err;
    logic        dec_err;
    logic [3:0]  strb_nx;
    logic [1:0]  slot;
    logic [7:0]  timeout_cnt;
    logic [7:0]  timeout_inc;
    logic        psel_on;
    logic        penable_on;
    logic        access_done;

    // A transfer request is NONSEQ or SEQ with the bridge selected.
    assign phase_req = bridge_hsel &&
                       ((biu_pad_htrans == 2'b10) ||
                        (biu_pad_htrans == 2'b11));

    // The bus is only released in states that can take a new phase.
    assign hready_int = (state == IDLE) ||
                        (state == RESP) ||
                        (state == ERR2);

    assign accept = phase_req && hready_int;

    // Decode checks on the live address phase.
    assign win_err   = biu_pad_haddr[31:14] != BASE_ADDR[31:14];
    assign size_err  = biu_pad_hsize > 3'd2;
    assign align_err = ((biu_pad_hsize == 3'd1) && biu_pad_haddr[0]) ||
                       ((biu_pad_hsize == 3'd2) && (|biu_pad_haddr[1:0]));
    assign dec_err   = win_err || size_err || align_err;

    always_comb begin
        strb_nx = 4'b1111;
        case (biu_pad_hsize)
            3'd0:    strb_nx = 4'b0001 << biu_pad_haddr[1:0];
            3'd1:    strb_nx = 4'b0011 << biu_pad_haddr[1:0];
            default: strb_nx = 4'b1111;
        endcase
    end

    assign timeout_inc = timeout_cnt + 8'd1;
    assign access_done = (state == ACCESS) && apb_pready;

    // Next state and bus-phase controls.
    always_comb begin
        state_nx   = state;
        psel_on    = 1'b0;
        penable_on = 1'b0;
        unique case (state)
            IDLE: begin
                if (phase_req) begin
                    state_nx = dec_err ? ERR1 : LATCH;
                end
            end
            LATCH: begin
                state_nx = SETUP;
            end
            SETUP: begin
                psel_on  = 1'b1;
                state_nx = ACCESS;
            end
            ACCESS: begin
                psel_on    = 1'b1;
                penable_on = 1'b1;
                if (apb_pready) begin
                    state_nx = apb_pslverr ? ERR1 : RESP;
                end else if (timeout_inc >= TIMEOUT) begin
                    // Give up: select drops on the ERR1 cycle.
                    state_nx = ERR1;
                end
            end
            RESP, ERR2: begin
                if (phase_req) begin
                    state_nx = dec_err ? ERR1 : LATCH;
                end else begin
                    state_nx = IDLE;
                end
            end
            ERR1: begin
                state_nx = ERR2;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Address-phase capture and APB/AHB data registers.
    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            slot           <= 2'b00;
            apb_paddr      <= 12'h000;
            apb_pwrite     <= 1'b0;
            apb_pstrb      <= 4'h0;
            apb_pwdata     <= 32'h0;
            pad_biu_hrdata <= 32'h0;
            timeout_cnt    <= 8'h00;
        end else begin
            // Erroring phases never reach APB, so the held
            // controls keep describing the last real access.
            if (accept && !dec_err) begin
                slot       <= biu_pad_haddr[13:12];
                apb_paddr  <= biu_pad_haddr[11:0];
                apb_pwrite <= biu_pad_hwrite;
                apb_pstrb  <= biu_pad_hwrite ? strb_nx : 4'h0;
            end
            if ((state == LATCH) && apb_pwrite) begin
                apb_pwdata <= biu_pad_hwdata;
            end
            if (state == SETUP) begin
                timeout_cnt <= 8'h00;
            end else if ((state == ACCESS) && !apb_pready) begin
                timeout_cnt <= timeout_inc;
            end
            if (access_done && !apb_pslverr && !apb_pwrite) begin
                pad_biu_hrdata <= apb_prdata;
            end
        end
    end

    assign apb_psel       = psel_on ? (4'b0001 << slot) : 4'b0000;
    assign apb_penable    = penable_on;
    assign pad_biu_hready = hready_int;
    assign pad_biu_hresp  = ((state == ERR1) || (state == ERR2)) ?
                            2'b01 : 2'b00;

endmodule

// File: tb/tb_apb_bridge_ahbl.sv
// Self-checking bench for apb_bridge_ahbl: scenario tasks drive AHB
// phases, a behavioural APB slave answers, a queue holds expectations.

`timescale 1ns/1ps

module tb_apb_bridge_ahbl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hsel = 1'b0;
    logic [31:0] haddr = 32'h0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd0;
    logic [31:0] hwdata = 32'h0;
    logic [31:0] hrdata;
    logic        hready;
    logic [1:0]  hresp;
    logic [3:0]  psel;
    logic        penable;
    logic [11:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata = 32'h0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    apb_bridge_ahbl #(
        .BASE_ADDR(32'h4000_0000),
        .TIMEOUT  (8'd4)
    ) dut (
        .pll_core_cpuclk(clk),
        .pad_cpu_rst_b  (rst_n),
        .bridge_hsel    (hsel),
        .biu_pad_haddr  (haddr),
        .biu_pad_htrans (htrans),
        .biu_pad_hwrite (hwrite),
        .biu_pad_hsize  (hsize),
        .biu_pad_hwdata (hwdata),
        .pad_biu_hrdata (hrdata),
        .pad_biu_hready (hready),
        .pad_biu_hresp  (hresp),
        .apb_psel       (psel),
        .apb_penable    (penable),
        .apb_paddr      (paddr),
        .apb_pwrite     (pwrite),
        .apb_pwdata     (pwdata),
        .apb_pstrb      (pstrb),
        .apb_prdata     (prdata),
        .apb_pready     (pready),
        .apb_pslverr    (pslverr)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [3:0]  psel;
        logic [11:0] paddr;
        logic [3:0]  pstrb;
        logic [31:0] wdata;
    } exp_t;

    exp_t exp_q[$];

    // Behavioural APB slave and access recorder.
    int          slv_wait = 0;
    logic        slv_err = 1'b0;
    logic [31:0] slv_rdata = 32'h0;
    int          acc_cnt = 0;
    int          cyc = 0;
    int          rdy_cyc = 0;
    logic        psel_seen = 1'b0;
    int          stab_err = 0;
    logic [11:0] set_paddr, cap_paddr;
    logic [31:0] set_pwdata, cap_pwdata;
    logic [3:0]  set_pstrb, cap_pstrb, cap_psel;
    logic        set_pwrite, cap_pwrite;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (|psel) psel_seen = 1'b1;
        if (|psel && !penable) begin
            set_paddr  = paddr;
            set_pwdata = pwdata;
            set_pstrb  = pstrb;
            set_pwrite = pwrite;
        end
        if (|psel && penable) begin
            if (paddr !== set_paddr || pwdata !== set_pwdata ||
                pstrb !== set_pstrb || pwrite !== set_pwrite)
                stab_err++;
            if (acc_cnt == slv_wait) begin
                pready     = 1'b1;
                pslverr    = slv_err;
                prdata     = slv_rdata;
                cap_paddr  = paddr;
                cap_pwdata = pwdata;
                cap_pstrb  = pstrb;
                cap_psel   = psel;
                cap_pwrite = pwrite;
                rdy_cyc    = cyc;
            end else begin
                pready  = 1'b0;
                pslverr = 1'b0;
            end
            acc_cnt++;
        end else begin
            pready  = 1'b0;
            pslverr = 1'b0;
            acc_cnt = 0;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic wr,
                              input logic [2:0] sz);
        hsel   = 1'b1;
        htrans = 2'b10;
        haddr  = a;
        hwrite = wr;
        hsize  = sz;
    endtask

    task automatic bus_idle();
        hsel   = 1'b0;
        htrans = 2'b00;
    endtask

    function automatic void push_exp(input logic wr, input logic [1:0] resp,
                                     input logic [31:0] rdata,
                                     input logic [3:0] ps,
                                     input logic [11:0] pa,
                                     input logic [3:0] st,
                                     input logic [31:0] wd);
        exp_t e;
        e.wr = wr; e.resp = resp; e.rdata = rdata; e.psel = ps;
        e.paddr = pa; e.pstrb = st; e.wdata = wd;
        exp_q.push_back(e);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus_idle();
        repeat (2) tick();
        checks++;
        if (hready !== 1'b1 || hresp !== 2'b00) begin
            errors++;
            $display("FAIL rst_ahb: hready=%b hresp=%b want 1/00", hready, hresp);
        end
        checks++;
        if (hrdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_hrdata: got %h want 0", hrdata);
        end
        checks++;
        if (psel !== 4'h0 || penable !== 1'b0 || paddr !== 12'h0 ||
            pwrite !== 1'b0 || pwdata !== 32'h0 || pstrb !== 4'h0) begin
            errors++;
            $display("FAIL rst_apb: psel=%b pen=%b paddr=%h pwr=%b pwd=%h pstrb=%b want all 0",
                     psel, penable, paddr, pwrite, pwdata, pstrb);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_word_write();
        exp_t e;
        slv_wait = 0;
        slv_err  = 1'b0;
        addr_phase(32'h4000_1004, 1'b1, 3'd2);
        push_exp(1'b1, 2'b00, 32'h0, 4'b0010, 12'h004, 4'hF, 32'hDEAD_BEEF);
        tick();
        bus_idle();
        hwdata = 32'hDEAD_BEEF;
        checks++;
        if (hready !== 1'b0) begin
            errors++;
            $display("FAIL ww_t1: hready=%b want 0", hready);
        end
        tick();
        checks++;
        if (psel !== 4'b0010 || penable !== 1'b0 || paddr !== 12'h004 ||
            pstrb !== 4'hF || hready !== 1'b0) begin
            errors++;
            $display("FAIL ww_setup: psel=%b pen=%b paddr=%h pstrb=%h hready=%b want 0010/0/004/f/0",
                     psel, penable, paddr, pstrb, hready);
        end
        tick();
        checks++;
        if (psel !== 4'b0010 || penable !== 1'b1 || pwdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL ww_access: psel=%b pen=%b pwdata=%h want 0010/1/deadbeef",
                     psel, penable, pwdata);
        end
        tick();
        checks++;
        if (hready !== 1'b1 || hresp !== 2'b00) begin
            errors++;
            $display("FAIL ww_t4: hready=%b hresp=%b want 1/00", hready, hresp);
        end
        e = exp_q.pop_front();
        checks++;
        if (cap_pwdata !== e.wdata || cap_pstrb !== e.pstrb ||
            cap_paddr !== e.paddr || cap_psel !== e.psel || cap_pwrite !== e.wr) begin
            errors++;
            $display("FAIL ww_sb: pwd=%h strb=%b paddr=%h psel=%b pwr=%b want %h/%b/%h/%b/%b",
                     cap_pwdata, cap_pstrb, cap_paddr, cap_psel, cap_pwrite,
                     e.wdata, e.pstrb, e.paddr, e.psel, e.wr);
        end
        tick();
    endtask

    task automatic test_byte_read();
        exp_t e;
        int   n;
        bit   ok;
        slv_wait  = 3;
        slv_rdata = 32'h1234_5678;
        addr_phase(32'h4000_3002, 1'b0, 3'd0);
        push_exp(1'b0, 2'b00, 32'h1234_5678, 4'b1000, 12'h002, 4'h0, 32'h0);
        tick();
        bus_idle();
        hwdata = 32'hFFFF_FFFF;
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (hready) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || n != 6) begin
            errors++;
            $display("FAIL br_latency: done=%0d after %0d cycles want 1 after 6", ok, n);
        end
        checks++;
        if (cyc - rdy_cyc != 1) begin
            errors++;
            $display("FAIL br_ready_gap: %0d cycles want 1", cyc - rdy_cyc);
        end
        e = exp_q.pop_front();
        checks++;
        if (hresp !== e.resp || hrdata !== e.rdata) begin
            errors++;
            $display("FAIL br_data: hresp=%b hrdata=%h want %b/%h", hresp, hrdata, e.resp, e.rdata);
        end
        checks++;
        if (cap_psel !== e.psel || cap_pstrb !== e.pstrb ||
            cap_paddr !== e.paddr || cap_pwrite !== e.wr) begin
            errors++;
            $display("FAIL br_apb: psel=%b strb=%b paddr=%h pwr=%b want %b/%b/%h/%b",
                     cap_psel, cap_pstrb, cap_paddr, cap_pwrite, e.psel, e.pstrb, e.paddr, e.wr);
        end
        checks++;
        if (stab_err != 0) begin
            errors++;
            $display("FAIL br_stable: %0d unstable access cycles want 0", stab_err);
        end
        slv_wait = 0;
        tick();
    endtask

    task automatic test_slverr();
        exp_t e;
        slv_wait = 0;
        slv_err  = 1'b1;
        addr_phase(32'h4000_0000, 1'b1, 3'd2);
        push_exp(1'b1, 2'b01, 32'h0, 4'b0001, 12'h000, 4'hF, 32'h0BAD_F00D);
        tick();
        bus_idle();
        hwdata = 32'h0BAD_F00D;
        repeat (3) tick();
        checks++;
        if (hready !== 1'b0 || hresp !== 2'b01 || psel !== 4'h0) begin
            errors++;
            $display("FAIL se_err1: hready=%b hresp=%b psel=%b want 0/01/0000", hready, hresp, psel);
        end
        tick();
        e = exp_q.pop_front();
        checks++;
        if (hready !== 1'b1 || hresp !== e.resp) begin
            errors++;
            $display("FAIL se_err2: hready=%b hresp=%b want 1/%b", hready, hresp, e.resp);
        end
        checks++;
        if (cap_pwdata !== e.wdata || cap_pstrb !== e.pstrb || cap_psel !== e.psel) begin
            errors++;
            $display("FAIL se_apb: pwd=%h strb=%b psel=%b want %h/%b/%b",
                     cap_pwdata, cap_pstrb, cap_psel, e.wdata, e.pstrb, e.psel);
        end
        slv_err = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        exp_t e;
        int   acc;
        bit   ok;
        slv_wait = 1000;
        addr_phase(32'h4000_0008, 1'b0, 3'd2);
        push_exp(1'b0, 2'b01, 32'h1234_5678, 4'b0001, 12'h008, 4'h0, 32'h0);
        tick();
        bus_idle();
        tick();
        acc = 0;
        ok  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (penable) begin
                acc++;
            end else begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || acc != 4) begin
            errors++;
            $display("FAIL to_cycles: ended=%0d after %0d access cycles want 1 after 4", ok, acc);
        end
        checks++;
        if (psel !== 4'h0 || hready !== 1'b0 || hresp !== 2'b01) begin
            errors++;
            $display("FAIL to_err1: psel=%b hready=%b hresp=%b want 0000/0/01", psel, hready, hresp);
        end
        tick();
        e = exp_q.pop_front();
        checks++;
        if (hready !== 1'b1 || hresp !== e.resp || hrdata !== e.rdata) begin
            errors++;
            $display("FAIL to_err2: hready=%b hresp=%b hrdata=%h want 1/%b/%h",
                     hready, hresp, hrdata, e.resp, e.rdata);
        end
        slv_wait = 0;
        tick();
    endtask

    task automatic test_decode_err();
        exp_t e;
        psel_seen = 1'b0;
        addr_phase(32'h5000_0000, 1'b0, 3'd2);
        push_exp(1'b0, 2'b01, 32'h1234_5678, 4'h0, 12'h0, 4'h0, 32'h0);
        tick();
        bus_idle();
        checks++;
        if (hready !== 1'b0 || hresp !== 2'b01) begin
            errors++;
            $display("FAIL de_win1: hready=%b hresp=%b want 0/01", hready, hresp);
        end
        tick();
        e = exp_q.pop_front();
        checks++;
        if (hready !== 1'b1 || hresp !== e.resp) begin
            errors++;
            $display("FAIL de_win2: hready=%b hresp=%b want 1/%b", hready, hresp, e.resp);
        end
        addr_phase(32'h4000_0001, 1'b1, 3'd1);
        push_exp(1'b1, 2'b01, 32'h0, 4'h0, 12'h0, 4'h0, 32'h0);
        tick();
        checks++;
        if (hready !== 1'b0 || hresp !== 2'b01) begin
            errors++;
            $display("FAIL de_half1: hready=%b hresp=%b want 0/01", hready, hresp);
        end
        addr_phase(32'h4000_0000, 1'b0, 3'd2);
        tick();
        bus_idle();
        e = exp_q.pop_front();
        checks++;
        if (hready !== 1'b1 || hresp !== e.resp) begin
            errors++;
            $display("FAIL de_half2: hready=%b hresp=%b want 1/%b", hready, hresp, e.resp);
        end
        tick();
        checks++;
        if (hready !== 1'b1 || hresp !== 2'b00) begin
            errors++;
            $display("FAIL de_ignored: hready=%b hresp=%b want 1/00", hready, hresp);
        end
        addr_phase(32'h4000_0000, 1'b0, 3'd3);
        push_exp(1'b0, 2'b01, 32'h0, 4'h0, 12'h0, 4'h0, 32'h0);
        tick();
        bus_idle();
        checks++;
        if (hready !== 1'b0 || hresp !== 2'b01) begin
            errors++;
            $display("FAIL de_size1: hready=%b hresp=%b want 0/01", hready, hresp);
        end
        tick();
        e = exp_q.pop_front();
        checks++;
        if (hready !== 1'b1 || hresp !== e.resp) begin
            errors++;
            $display("FAIL de_size2: hready=%b hresp=%b want 1/%b", hready, hresp, e.resp);
        end
        tick();
        checks++;
        if (psel_seen !== 1'b0) begin
            errors++;
            $display("FAIL de_no_psel: psel_seen=%b want 0", psel_seen);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        slv_wait  = 0;
        slv_rdata = 32'hA5A5_0001;
        stab_err  = 0;
        addr_phase(32'h4000_2010, 1'b0, 3'd2);
        push_exp(1'b0, 2'b00, 32'hA5A5_0001, 4'b0100, 12'h010, 4'h0, 32'h0);
        tick();
        bus_idle();
        repeat (3) tick();
        e = exp_q.pop_front();
        checks++;
        if (hready !== 1'b1 || hresp !== e.resp || hrdata !== e.rdata ||
            cap_psel !== e.psel || cap_paddr !== e.paddr) begin
            errors++;
            $display("FAIL b2b_first: hready=%b hresp=%b hrdata=%h psel=%b paddr=%h want 1/%b/%h/%b/%h",
                     hready, hresp, hrdata, cap_psel, cap_paddr, e.resp, e.rdata, e.psel, e.paddr);
        end
        addr_phase(32'h4000_0020, 1'b0, 3'd2);
        slv_rdata = 32'hA5A5_0002;
        push_exp(1'b0, 2'b00, 32'hA5A5_0002, 4'b0001, 12'h020, 4'h0, 32'h0);
        tick();
        bus_idle();
        checks++;
        if (hready !== 1'b0 || psel !== 4'h0) begin
            errors++;
            $display("FAIL b2b_latch: hready=%b psel=%b want 0/0000", hready, psel);
        end
        tick();
        checks++;
        if (psel !== 4'b0001 || penable !== 1'b0 || paddr !== 12'h020) begin
            errors++;
            $display("FAIL b2b_setup: psel=%b pen=%b paddr=%h want 0001/0/020", psel, penable, paddr);
        end
        repeat (2) tick();
        e = exp_q.pop_front();
        checks++;
        if (hready !== 1'b1 || hresp !== e.resp || hrdata !== e.rdata || stab_err != 0) begin
            errors++;
            $display("FAIL b2b_second: hready=%b hresp=%b hrdata=%h unstable=%0d want 1/%b/%h/0",
                     hready, hresp, hrdata, stab_err, e.resp, e.rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        slv_wait = 3;
        addr_phase(32'h4000_1030, 1'b1, 3'd2);
        tick();
        bus_idle();
        hwdata = 32'h7777_0000;
        repeat (3) tick();
        checks++;
        if (psel !== 4'b0010 || penable !== 1'b1) begin
            errors++;
            $display("FAIL rm_access: psel=%b pen=%b want 0010/1", psel, penable);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (psel !== 4'h0 || penable !== 1'b0 || hready !== 1'b1 ||
            hresp !== 2'b00 || hrdata !== 32'h0) begin
            errors++;
            $display("FAIL rm_ctrl: psel=%b pen=%b hready=%b hresp=%b hrdata=%h want 0/0/1/00/0",
                     psel, penable, hready, hresp, hrdata);
        end
        checks++;
        if (paddr !== 12'h0 || pwdata !== 32'h0 || pstrb !== 4'h0 || pwrite !== 1'b0) begin
            errors++;
            $display("FAIL rm_data: paddr=%h pwd=%h strb=%b pwr=%b want all 0",
                     paddr, pwdata, pstrb, pwrite);
        end
        tick();
        rst_n    = 1'b1;
        slv_wait = 0;
        addr_phase(32'h4000_2006, 1'b1, 3'd1);
        push_exp(1'b1, 2'b00, 32'h0, 4'b0100, 12'h006, 4'b1100, 32'hBEEF_0000);
        tick();
        bus_idle();
        hwdata = 32'hBEEF_0000;
        checks++;
        if (hready !== 1'b0) begin
            errors++;
            $display("FAIL rm_first_edge: hready=%b want 0", hready);
        end
        repeat (3) tick();
        e = exp_q.pop_front();
        checks++;
        if (hready !== 1'b1 || cap_pstrb !== e.pstrb || cap_paddr !== e.paddr ||
            cap_pwdata !== e.wdata || cap_psel !== e.psel) begin
            errors++;
            $display("FAIL rm_half: hready=%b strb=%b paddr=%h pwd=%h psel=%b want 1/%b/%h/%h/%b",
                     hready, cap_pstrb, cap_paddr, cap_pwdata, cap_psel,
                     e.pstrb, e.paddr, e.wdata, e.psel);
        end
        tick();
    endtask

    task automatic test_strobes();
        exp_t        e;
        logic [31:0] addr_t [4] = '{32'h4000_0001, 32'h4000_3003,
                                    32'h4000_1000, 32'h4000_2002};
        logic [2:0]  size_t [4] = '{3'd0, 3'd0, 3'd1, 3'd0};
        logic [3:0]  strb_t [4] = '{4'b0010, 4'b1000, 4'b0011, 4'b0100};
        for (int i = 0; i < 4; i++) begin
            addr_phase(addr_t[i], 1'b1, size_t[i]);
            push_exp(1'b1, 2'b00, 32'h0, 4'b0001 << addr_t[i][13:12],
                     addr_t[i][11:0], strb_t[i], 32'hC0DE_0000 + i);
            tick();
            bus_idle();
            hwdata = 32'hC0DE_0000 + i;
            repeat (3) tick();
            e = exp_q.pop_front();
            checks++;
            if (hready !== 1'b1 || hresp !== e.resp || cap_pstrb !== e.pstrb ||
                cap_paddr !== e.paddr || cap_psel !== e.psel || cap_pwdata !== e.wdata) begin
                errors++;
                $display("FAIL strb_%0d: hready=%b strb=%b paddr=%h psel=%b pwd=%h want 1/%b/%h/%b/%h",
                         i, hready, cap_pstrb, cap_paddr, cap_psel, cap_pwdata,
                         e.pstrb, e.paddr, e.psel, e.wdata);
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_word_write();
        test_byte_read();
        test_slverr();
        test_timeout();
        test_decode_err();
        test_back_to_back();
        test_reset_mid();
        test_strobes();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d entries want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
